// File: rtl/exc_pkg.sv
// Shared exception-code definitions and the oldest-wins merge used by the
// exception-tracking pipeline.
package exc_pkg;

    localparam int EXC_EW = 5;
    localparam int EXC_MW = 16;  // widest code the merge helper handles

    localparam logic [EXC_EW-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_EW-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_EW-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_EW-1:0] EXC_SYS  = 5'd8;
    localparam logic [EXC_EW-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_EW-1:0] EXC_OV   = 5'd12;

    // An already-recorded code wins over a newly detected one.
    function automatic logic [EXC_MW-1:0] exc_merge(input logic [EXC_MW-1:0] a,
                                                    input logic [EXC_MW-1:0] b);
        return (a != '0) ? a : b;
    endfunction

endpackage

// File: rtl/exc_slot.sv
// One tracked pipeline slot: valid, PC and exception code with clear/load/hold.
module exc_slot
    import exc_pkg::*;
#(
    parameter int AW = 32,
    parameter int EW = EXC_EW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld,
    input  logic          d_v,
    input  logic [AW-1:0] d_pc,
    input  logic [EW-1:0] d_code,
    output logic          v,
    output logic [AW-1:0] pc,
    output logic [EW-1:0] code
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v    <= 1'b0;
            pc   <= '0;
            code <= '0;
        end else if (clr) begin
            v    <= 1'b0;
            code <= '0;
        end else if (ld) begin
            v    <= d_v;
            pc   <= d_pc;
            code <= d_v ? d_code : '0;
        end
    end

endmodule

// File: rtl/exc_pipe_tracker.sv
// Carries PC and exception code through STAGES slots and hands the surviving
// exception at the last slot to CP0 over a req/ack handshake.
module exc_pipe_tracker
    import exc_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int EW     = EXC_EW,
    parameter int AW     = 32,
    parameter int CW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [AW-1:0]        in_pc,
    input  logic [EW-1:0]        in_exc,
    input  logic [STAGES*EW-1:0] stage_exc,
    output logic                 exc_req,
    output logic [EW-1:0]        exc_code,
    output logic [AW-1:0]        exc_pc,
    input  logic                 exc_ack,
    output logic                 busy,
    output logic [CW-1:0]        exc_cnt
);

    localparam int L = STAGES - 1;

    logic [STAGES-1:0]         v, d_v, clr;
    logic [STAGES-1:0][AW-1:0] pc, d_pc;
    logic [STAGES-1:0][EW-1:0] code, d_code, merged;
    logic                      capture, ack_done, adv;

    // Codes detected by an empty slot are dropped here.
    for (genvar s = 0; s < STAGES; s++) begin : g_merge
        assign merged[s] = v[s] ?
            EW'(exc_merge(EXC_MW'(code[s]), EXC_MW'(stage_exc[s*EW +: EW]))) : '0;
    end

    assign capture  = !exc_req && !flush && v[L] && (merged[L] != '0);
    assign ack_done = exc_req && exc_ack;
    // Capture freezes the younger slots for the edge on which it happens.
    assign adv      = !stall && !flush && !exc_req && !capture;

    for (genvar s = 0; s < STAGES; s++) begin : g_slot
        if (s == 0) begin : g_head
            assign d_v[s]    = in_valid;
            assign d_pc[s]   = in_pc;
            assign d_code[s] = in_exc;
        end else begin : g_body
            assign d_v[s]    = v[s-1];
            assign d_pc[s]   = pc[s-1];
            assign d_code[s] = merged[s-1];
        end
        assign clr[s] = flush || ack_done || ((s == L) && capture);

        exc_slot #(.AW(AW), .EW(EW)) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr[s]),
            .ld     (adv),
            .d_v    (d_v[s]),
            .d_pc   (d_pc[s]),
            .d_code (d_code[s]),
            .v      (v[s]),
            .pc     (pc[s]),
            .code   (code[s])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_req  <= 1'b0;
            exc_code <= '0;
            exc_pc   <= '0;
            exc_cnt  <= '0;
        end else if (capture) begin
            exc_req  <= 1'b1;
            exc_code <= merged[L];
            exc_pc   <= pc[L];
        end else if (ack_done) begin
            exc_req <= 1'b0;
            if (exc_cnt != '1) exc_cnt <= exc_cnt + 1'b1;
        end
    end

    assign busy = exc_req;

endmodule

// File: tb/tb_exc_pipe_tracker.sv
// Directed table-driven bench for exc_pipe_tracker (STAGES=4, CW=2 so the
// counter saturates within the run).
module tb_exc_pipe_tracker;

    localparam int STAGES = 4;
    localparam int EW     = 5;
    localparam int AW     = 32;
    localparam int CW     = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 stall = 1'b0, flush = 1'b0, in_valid = 1'b0, exc_ack = 1'b0;
    logic [AW-1:0]        in_pc = '0;
    logic [EW-1:0]        in_exc = '0;
    logic [STAGES*EW-1:0] stage_exc = '0;
    logic                 exc_req, busy;
    logic [EW-1:0]        exc_code;
    logic [AW-1:0]        exc_pc;
    logic [CW-1:0]        exc_cnt;

    exc_pipe_tracker #(.STAGES(STAGES), .EW(EW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_exc(in_exc), .stage_exc(stage_exc),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_ack(exc_ack),
        .busy(busy), .exc_cnt(exc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st, fl, iv, ack;
        logic [AW-1:0] pc;
        logic [EW-1:0] ie;
        int            si;
        logic [EW-1:0] sv;
        logic          req;
        logic [EW-1:0] code;
        logic [AW-1:0] epc;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0, n_err = 0;

    // Expected exception registers for rows added next.
    logic [EW-1:0] ec = '0;
    logic [AW-1:0] ep = '0;
    logic [CW-1:0] cn = '0;

    function automatic void row(logic st, logic fl, logic iv, logic [AW-1:0] pc,
                                logic [EW-1:0] ie, int si, logic [EW-1:0] sv,
                                logic ack, logic req);
        vec_t t;
        t.st = st; t.fl = fl; t.iv = iv; t.pc = pc; t.ie = ie;
        t.si = si; t.sv = sv; t.ack = ack;
        t.req = req; t.code = ec; t.epc = ep; t.cnt = cn;
        tbl.push_back(t);
    endfunction

    function automatic void idle(int n, logic req);
        for (int i = 0; i < n; i++) row(0, 0, 0, '0, '0, 0, '0, 0, req);
    endfunction

    task automatic check(string name, logic req, logic [EW-1:0] code,
                         logic [AW-1:0] epc, logic [CW-1:0] cnt);
        n_vec++;
        if ({exc_req, busy, exc_code, exc_pc, exc_cnt} !== {req, req, code, epc, cnt}) begin
            n_err++;
            $display("FAIL %s: got req=%b busy=%b code=%0d pc=%h cnt=%0d, want req=%b code=%0d pc=%h cnt=%0d",
                     name, exc_req, busy, exc_code, exc_pc, exc_cnt, req, code, epc, cnt);
        end
    endtask

    task automatic apply(vec_t t, int idx);
        stall = t.st; flush = t.fl; in_valid = t.iv; in_pc = t.pc; in_exc = t.ie;
        exc_ack = t.ack;
        stage_exc = '0;
        stage_exc[t.si*EW +: EW] = t.sv;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d", idx), t.req, t.code, t.epc, t.cnt);
    endtask

    initial begin
        // Single exception detected at slot 2, then held with noise, then acked.
        row(0, 0, 1, 32'h3000, 0, 0, 0, 0, 0);
        idle(2, 0);
        row(0, 0, 0, '0, 0, 2, 5'd12, 0, 0);
        ec = 12; ep = 32'h3000;
        idle(1, 1);
        row(0, 0, 1, 32'h4000, 5'd8, 2, 5'd5, 0, 1);
        row(1, 0, 1, 32'h4000, 5'd8, 3, 5'd4, 0, 1);
        row(0, 1, 0, '0, 0, 0, 0, 0, 1);
        idle(2, 1);
        cn = 1;
        row(0, 0, 0, '0, 0, 0, 0, 1, 0);
        idle(6, 0);
        // Priority: fetch code 4 beats a later code 10; ack on the first pending cycle.
        row(0, 0, 1, 32'h100, 5'd4, 0, 0, 0, 0);
        idle(1, 0);
        row(0, 0, 0, '0, 0, 1, 5'd10, 0, 0);
        idle(1, 0);
        ec = 4; ep = 32'h100;
        idle(1, 1);
        cn = 2;
        row(0, 0, 0, '0, 0, 0, 0, 1, 0);
        // Flush together with ack still completes the handshake.
        row(0, 0, 1, 32'h600, 5'd10, 0, 0, 0, 0);
        idle(3, 0);
        ec = 10; ep = 32'h600;
        idle(1, 1);
        cn = 3;
        row(0, 1, 0, '0, 0, 0, 0, 1, 0);
        idle(5, 0);
        // Stall at slot 1: mid-stall pulse of 12 must be ignored.
        row(0, 0, 1, 32'h200, 0, 0, 0, 0, 0);
        idle(1, 0);
        row(1, 0, 0, '0, 0, 0, 0, 0, 0);
        row(1, 0, 0, '0, 0, 1, 5'd12, 0, 0);
        row(1, 0, 0, '0, 0, 0, 0, 0, 0);
        row(0, 0, 0, '0, 0, 1, 0, 0, 0);
        idle(5, 0);
        // Stall delays an exception by 3 edges; capture and ack under stall; counter saturated.
        row(0, 0, 1, 32'h300, 5'd8, 0, 0, 0, 0);
        idle(1, 0);
        row(1, 0, 0, '0, 0, 0, 0, 0, 0);
        row(1, 0, 0, '0, 0, 0, 0, 0, 0);
        row(1, 0, 0, '0, 0, 0, 0, 0, 0);
        idle(2, 0);
        ec = 8; ep = 32'h300;
        row(1, 0, 0, '0, 0, 0, 0, 0, 1);
        row(1, 0, 0, '0, 0, 0, 0, 1, 0);
        idle(2, 0);
        // Flush with a code-5 instruction in slot 2: never captured.
        row(0, 0, 1, 32'h500, 5'd5, 0, 0, 0, 0);
        idle(2, 0);
        row(0, 1, 0, '0, 0, 0, 0, 0, 0);
        idle(5, 0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 0, '0, '0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset", 0, '0, '0, '0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Async reset in the middle of a pending handshake.
        ec = 12; ep = 32'h700;
        apply('{st:0, fl:0, iv:1, ack:0, pc:32'h700, ie:5'd12, si:0, sv:'0,
                req:0, code:5'd8, epc:32'h300, cnt:2'd3}, 900);
        for (int i = 0; i < 3; i++)
            apply('{st:0, fl:0, iv:0, ack:0, pc:'0, ie:'0, si:0, sv:'0,
                    req:0, code:5'd8, epc:32'h300, cnt:2'd3}, 901 + i);
        apply('{st:0, fl:0, iv:0, ack:0, pc:'0, ie:'0, si:0, sv:'0,
                req:1, code:ec, epc:ep, cnt:2'd3}, 904);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 0, '0, '0, '0);
        @(negedge clk);
        check("reset_held", 0, '0, '0, '0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("after_async_reset", 0, '0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exc_pipe_tracker.md
# exc_pipe_tracker

Parametrised exception-tracking pipeline for the CPU. Carries each in-flight instruction's PC and exception code through `STAGES` pipeline slots. At every slot it merges in newly detected codes with oldest-wins priority: an already-recorded non-zero code is kept, otherwise the new code is taken. The surviving exception is presented at the last slot to CP0 through a req/ack handshake. Sits alongside the main datapath registers and replaces ad-hoc per-stage code selection.

## Interface
- `STAGES`, 4, number of tracked pipeline slots (≥2).
- `EW`, 5, exception-code width; code 0 means "no exception".
- `AW`, 32, PC width.
- `CW`, 16, width of the committed-exception counter.

- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `stall` in 1: hold all slots this cycle.
- `flush` in 1: invalidate all slots this cycle.
- `in_valid` in 1: instruction entering slot 0.
- `in_pc` in AW: its PC.
- `in_exc` in EW: code detected at fetch.
- `stage_exc` in STAGES*EW: code detected by the logic of slot s, in bits [s*EW +: EW]. Combinational against slot s contents.
- `exc_req` out 1: exception pending for CP0.
- `exc_code` out EW: pending code.
- `exc_pc` out AW: PC of the faulting instruction.
- `exc_ack` in 1: CP0 accepts; sampled only while `exc_req`=1.
- `busy` out 1: equals `exc_req`; upstream must stall fetch while high.
- `exc_cnt` out CW: count of acknowledged exceptions, saturating.

## Operation
- Each slot s holds `v[s]`, `pc[s]` and `code[s]`.
- Merge rule: m(a,b) = (a != 0) ? a : b.
- `adv` = !stall && !flush && !exc_req.
- On `adv`:
  - slot 0 loads {in_valid, in_pc, in_exc}.
  - slot s+1 loads {v[s], pc[s], m(code[s], stage_exc[s])}.
  - The code of an invalid slot is forced to 0.
- `stage_exc[s]` affects state only on an `adv` edge, or on a capture edge for the last slot. Its value is ignored when `v[s]`=0.
- Capture happens when !exc_req && !flush && v[L] && m(code[L], stage_exc[L]) != 0, with L = STAGES-1. On that edge:
  - `exc_req` is set to 1.
  - `exc_code` takes the merged value and `exc_pc` takes pc[L].
  - v[L] is cleared.
  - Slots 0..L-1 do not advance, because capture freezes the pipeline.
- Pending: `exc_req`, `exc_code` and `exc_pc` are stable and all slots are frozen until the handshake completes.
- Handshake completes on an edge with exc_req && exc_ack:
  - `exc_req` is cleared.
  - All `v` are cleared (younger instructions are discarded).
  - `exc_cnt` is incremented and saturates at all-ones.
  - `exc_code` and `exc_pc` hold their last values.
- `flush` while idle clears all `v`; no capture occurs that cycle.
- `flush` while pending clears `v` and leaves `exc_req` untouched.
- `flush` and `exc_ack` on the same edge: ack completes and all slots are cleared.
- `stall` does not block capture or ack.
- Reset (asynchronous, any time including mid-handshake): all `v`, `pc` and `code` go to 0; `exc_req`=0, `busy`=0, `exc_code`=0, `exc_pc`=0, `exc_cnt`=0.

## Timing
- An instruction loaded into slot 0 at edge t0 reaches slot L at edge t0+L, assuming no stalls.
- A code detected at slot s reaches slot s+1 on the next `adv` edge. The earliest point `exc_req` can rise is one edge after the instruction reaches slot L.
- `exc_req` is registered and has no combinational path from any input.
- Minimum handshake: `exc_req` high for 1 cycle when `exc_ack` is held at 1.
- Two back-to-back exceptions are separated by at least L+1 edges after the ack, because all slots are flushed.

## Structure
- Shared package `exc_pkg`:
  - default `EW`.
  - `EXC_NONE`=0, `EXC_ADEL`=4, `EXC_ADES`=5, `EXC_SYS`=8, `EXC_RI`=10, `EXC_OV`=12.
  - merge function `exc_merge`.
- Sub-module `exc_slot`: one slot register with valid, pc and code, plus load/hold/clear control. Instantiated STAGES times via generate.
- Capture/handshake logic and the counter live in the top module.

## Test plan
- Single exception: STAGES=4, in_valid=1, in_pc=0x00003000, code 0 at edge t0; stage_exc[2]=12 while the instruction is in slot 2 → `exc_req`=1 after edge t0+4, `exc_code`=12, `exc_pc`=0x00003000.
- Priority: in_exc=4, then stage_exc[1]=10 on the same instruction → `exc_code`=4.
- Hold and ack: `exc_ack`=0 for 5 cycles → outputs stable, `busy`=1, slots frozen. Assert ack → next edge `exc_req`=0, all v=0, `exc_cnt`=1.
- Stall: stall=1 for 3 cycles with the instruction in slot 1 and stage_exc[1]=12 pulsed mid-stall, then released with stage_exc[1]=0 → no advance during stall; the pulse is ignored.
- Flush: flush=1 while an instruction with code 5 sits in slot 2 → `exc_req` never rises. Flush together with exc_ack → ack completes and `exc_cnt` increments.
- Async reset: assert rst_n=0 mid-handshake, between clock edges → `exc_req`=0 and `exc_cnt`=0 immediately.
